// File: rtl/mm_pkg.sv
// Shared defaults and types for the matrix-vector result collector.
// The top can be re-parameterised; these describe the default 32 x 16 / 128-bit build.
package mm_pkg;

  localparam int unsigned DwDefault    = 32;
  localparam int unsigned NDefault     = 16;
  localparam int unsigned OutWDefault  = 128;
  localparam int unsigned DepthDefault = 2;
  localparam int unsigned BEATS        = DwDefault * NDefault / OutWDefault;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BeatW = idx_w(BEATS);

  typedef logic [DwDefault*NDefault-1:0] vec_t;
  typedef logic [BeatW-1:0]              beat_idx_t;

endpackage

// File: rtl/mm_vec_fifo.sv
// Small vector FIFO: Depth entries of Width bits, head visible combinationally on rdata_o.
module mm_vec_fifo
  import mm_pkg::*;
#(
  parameter int unsigned Width = DwDefault * NDefault,
  parameter int unsigned Depth = DepthDefault,
  parameter int unsigned CntW  = idx_w(Depth + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CntW-1:0]  count_o
);

  localparam int unsigned PtrW = idx_w(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind a valid count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/mm_result_collector.sv
// Collects per-column matrix-unit results into vectors, queues them, and streams them out as beats
// while issuing credits so the feeder never overruns the queue.
module mm_result_collector
  import mm_pkg::*;
#(
  parameter int unsigned DW    = DwDefault,
  parameter int unsigned N     = NDefault,
  parameter int unsigned OUT_W = OutWDefault,
  parameter int unsigned DEPTH = DepthDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              collect_ready,
  input  logic [DW*N-1:0]   vector_output,
  input  logic [N-1:0]      add_valid,
  output logic [OUT_W-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_last,
  output logic [31:0]       vec_count,
  output logic              err_overflow,
  output logic              err_credit
);

  localparam int unsigned VecW  = DW * N;
  localparam int unsigned Beats = VecW / OUT_W;
  localparam int unsigned BW    = idx_w(Beats);
  localparam int unsigned CntW  = idx_w(DEPTH + 1);
  localparam int unsigned InflW = CntW + 1;

  if (VecW % OUT_W != 0) begin : g_bad_out_w
    $error("mm_result_collector: DW*N must be a multiple of OUT_W");
  end

  logic [N-1:0]      col_mask_q, col_mask_d;
  logic [VecW-1:0]   col_data_q, col_data_d;
  logic              complete, dup_hit;

  logic [InflW-1:0]  inflight_q, inflight_d;
  logic [InflW-1:0]  occupancy;
  logic              issue_ok;

  logic [BW-1:0]     beat_q, beat_d;
  logic [31:0]       vec_count_q, vec_count_d;
  logic              err_overflow_q, err_overflow_d;
  logic              err_credit_q, err_credit_d;

  logic [VecW-1:0]   head_vec;
  logic [OUT_W-1:0]  beat_data;
  logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [CntW-1:0]   fifo_count;
  logic              fire, last_beat;

  // Column capture: col_data_d doubles as the assembled vector on the completing cycle.
  always_comb begin
    col_mask_d = col_mask_q;
    col_data_d = col_data_q;
    dup_hit    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (add_valid[i]) begin
        if (col_mask_q[i]) begin
          dup_hit = 1'b1;
        end else begin
          col_data_d[i*DW +: DW] = vector_output[i*DW +: DW];
          col_mask_d[i]          = 1'b1;
        end
      end
    end
    complete = &(col_mask_q | add_valid);
    if (complete) begin
      col_mask_d = '0;
    end
  end

  assign fifo_push = complete & ~fifo_full;

  mm_vec_fifo #(
    .Width (VecW),
    .Depth (DEPTH),
    .CntW  (CntW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (col_data_d),
    .pop_i   (fifo_pop),
    .rdata_o (head_vec),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Credits cover both vectors still in the matrix unit and vectors waiting in the queue.
  always_comb begin
    occupancy     = inflight_q + InflW'(fifo_count);
    collect_ready = (occupancy < InflW'(DEPTH));
    issue_ok      = issue_valid & collect_ready;
    inflight_d    = inflight_q;
    case ({issue_ok, complete && (inflight_q != '0)})
      2'b10:   inflight_d = inflight_q + InflW'(1);
      2'b01:   inflight_d = inflight_q - InflW'(1);
      default: inflight_d = inflight_q;
    endcase
    err_credit_d   = err_credit_q | (issue_valid & ~collect_ready);
    err_overflow_d = err_overflow_q | dup_hit;
  end

  always_comb begin
    beat_data = '0;
    for (int b = 0; b < Beats; b++) begin
      if (beat_q == BW'(b)) begin
        beat_data = head_vec[b*OUT_W +: OUT_W];
      end
    end
  end

  // Beat sequencer: outputs come straight from the FIFO head, so they hold while stalled.
  always_comb begin
    m_valid     = ~fifo_empty;
    last_beat   = (beat_q == BW'(Beats - 1));
    m_last      = m_valid & last_beat;
    m_data      = m_valid ? beat_data : '0;
    fire        = m_valid & m_ready;
    fifo_pop    = fire & last_beat;
    beat_d      = beat_q;
    vec_count_d = vec_count_q;
    if (fire) begin
      if (last_beat) begin
        beat_d      = '0;
        vec_count_d = vec_count_q + 32'd1;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_mask_q     <= '0;
      col_data_q     <= '0;
      inflight_q     <= '0;
      beat_q         <= '0;
      vec_count_q    <= '0;
      err_overflow_q <= 1'b0;
      err_credit_q   <= 1'b0;
    end else begin
      col_mask_q     <= col_mask_d;
      col_data_q     <= col_data_d;
      inflight_q     <= inflight_d;
      beat_q         <= beat_d;
      vec_count_q    <= vec_count_d;
      err_overflow_q <= err_overflow_d;
      err_credit_q   <= err_credit_d;
    end
  end

  assign vec_count    = vec_count_q;
  assign err_overflow = err_overflow_q;
  assign err_credit   = err_credit_q;

endmodule

// File: tb/tb_mm_result_collector.sv
// Self-checking bench for mm_result_collector: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_mm_result_collector;

  localparam int DW    = 32;
  localparam int N     = 16;
  localparam int OUT_W = 128;
  localparam int DEPTH = 2;
  localparam int BEATS = DW * N / OUT_W;
  localparam int VW    = DW * N;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              issue_valid = 1'b0;
  logic              collect_ready;
  logic [VW-1:0]     vector_output = '0;
  logic [N-1:0]      add_valid = '0;
  logic [OUT_W-1:0]  m_data;
  logic              m_valid;
  logic              m_ready = 1'b0;
  logic              m_last;
  logic [31:0]       vec_count;
  logic              err_overflow;
  logic              err_credit;

  always #5 clk = ~clk;

  mm_result_collector dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .collect_ready (collect_ready),
    .vector_output (vector_output),
    .add_valid     (add_valid),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_last        (m_last),
    .vec_count     (vec_count),
    .err_overflow  (err_overflow),
    .err_credit    (err_credit)
  );

  // Reference model: queued vectors, beat position, outstanding credits, partial vector.
  logic [VW-1:0] q_vec [$];
  int            m_beat;
  int            m_inflight;
  logic [31:0]   m_cnt;
  bit            m_eov, m_ecr;
  logic [DW-1:0] part [N];
  bit            have [N];
  bit            rand_ready = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q_vec.delete();
    m_beat = 0; m_inflight = 0; m_cnt = 0; m_eov = 0; m_ecr = 0;
    for (int i = 0; i < N; i++) have[i] = 0;
  endtask

  function automatic bit model_credit();
    return (m_inflight + q_vec.size()) < DEPTH;
  endfunction

  task automatic check_outputs();
    logic [VW-1:0]    head;
    logic [OUT_W-1:0] exp_data;
    bit               ev;
    ev       = (q_vec.size() > 0);
    head     = ev ? q_vec[0] : '0;
    exp_data = ev ? head[m_beat*OUT_W +: OUT_W] : '0;
    chk("m_valid", m_valid, ev);
    chk("m_data", m_data, exp_data);
    chk("m_last", m_last, ev && (m_beat == BEATS - 1));
    chk("collect_ready", collect_ready, model_credit());
    chk("vec_count", vec_count, m_cnt);
    chk("err_overflow", err_overflow, m_eov);
    chk("err_credit", err_credit, m_ecr);
  endtask

  task automatic model_advance();
    bit            cr, pop_now, all;
    logic [VW-1:0] v;
    cr      = model_credit();
    pop_now = 0;
    if (issue_valid) begin
      if (cr) m_inflight++;
      else m_ecr = 1;
    end
    if (q_vec.size() > 0 && m_ready) begin
      if (m_beat == BEATS - 1) begin
        m_beat = 0; pop_now = 1; m_cnt++;
      end else begin
        m_beat++;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (add_valid[i]) begin
        if (have[i]) m_eov = 1;
        else begin
          part[i] = vector_output[i*DW +: DW];
          have[i] = 1;
        end
      end
    end
    all = 1;
    for (int i = 0; i < N; i++) if (!have[i]) all = 0;
    if (pop_now) void'(q_vec.pop_front());
    if (all) begin
      for (int i = 0; i < N; i++) begin
        v[i*DW +: DW] = part[i];
        have[i] = 0;
      end
      q_vec.push_back(v);
      if (m_inflight > 0) m_inflight--;
    end
  endtask

  // One clock: inputs are already driven; check, advance model, move to the next falling edge.
  task automatic step();
    if (rand_ready) m_ready = 1'($urandom_range(0, 1));
    check_outputs();
    model_advance();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input bit iv, input logic [N-1:0] av, input logic [VW-1:0] d);
    issue_valid   = iv;
    add_valid     = av;
    vector_output = d;
    step();
    issue_valid = 1'b0;
    add_valid   = '0;
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = $urandom;
    return r;
  endfunction

  // Bus value carrying v on strobed columns and junk elsewhere.
  function automatic logic [VW-1:0] mix(input logic [VW-1:0] v, input logic [N-1:0] av);
    logic [VW-1:0] d;
    d = rand_vec();
    for (int i = 0; i < N; i++) if (av[i]) d[i*DW +: DW] = v[i*DW +: DW];
    return d;
  endfunction

  // mode 0: one column per cycle ascending; 1: all at once; 2: random order, groups and gaps.
  task automatic send_cols(input logic [VW-1:0] v, input int mode);
    int            perm [N];
    int            k, j, tmp, take;
    logic [N-1:0]  av;
    if (mode == 1) begin
      drive(0, '1, mix(v, '1));
    end else begin
      for (int i = 0; i < N; i++) perm[i] = i;
      if (mode == 2) begin
        for (int i = N - 1; i > 0; i--) begin
          j = $urandom_range(0, i);
          tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
        end
      end
      k = 0;
      while (k < N) begin
        take = (mode == 2) ? $urandom_range(1, 3) : 1;
        av = '0;
        for (int t = 0; t < take && k < N; t++) begin
          av[perm[k]] = 1'b1;
          k++;
        end
        drive(0, av, mix(v, av));
        if (mode == 2 && $urandom_range(0, 2) == 0) drive(0, '0, rand_vec());
      end
    end
  endtask

  task automatic wait_credit(input int budget);
    int k = 0;
    while (!model_credit() && k < budget) begin
      drive(0, '0, rand_vec());
      k++;
    end
    chk("credit_wait", collect_ready, 1'b1);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    m_ready = 1'b1;
    while (q_vec.size() > 0 && k < budget) begin
      drive(0, '0, rand_vec());
      k++;
    end
    chk("drain_empty", m_valid, 1'b0);
  endtask

  initial begin
    logic [VW-1:0] v, v2;

    // 1: reset state
    model_reset();
    @(negedge clk);
    check_outputs();
    chk("rst_collect_ready", collect_ready, 1'b1);
    rst_n = 1'b1;
    step();

    // 2: ascending columns, m_ready high
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) v[i*DW +: DW] = 32'h100 + i;
    drive(1, '0, '0);
    send_cols(v, 0);
    chk("t2_beat0", m_data, 128'h00000103_00000102_00000101_00000100);
    drain(20);
    chk("t2_vec_count", vec_count, 32'd1);

    // 3: all columns in one cycle, then same data in random order
    v = rand_vec();
    m_ready = 1'b0;
    drive(1, '0, '0);
    send_cols(v, 1);
    chk("t3_valid_next", m_valid, 1'b1);
    drain(20);
    drive(1, '0, '0);
    send_cols(v, 2);
    drain(20);

    // 4: stall with two vectors, credit exhaustion
    m_ready = 1'b0;
    v = rand_vec();
    v2 = rand_vec();
    drive(1, '0, '0);
    send_cols(v, 2);
    drive(1, '0, '0);
    chk("t4_cr_low", collect_ready, 1'b0);
    drive(1, '0, '0);
    chk("t4_err_credit", err_credit, 1'b1);
    send_cols(v2, 0);
    for (int i = 0; i < 5; i++) drive(0, '0, rand_vec());
    drain(20);
    chk("t4_cr_back", collect_ready, 1'b1);

    // 5: duplicate strobe on column 5
    m_ready = 1'b0;
    v = rand_vec();
    v[5*DW +: DW] = 32'hA;
    drive(1, '0, '0);
    drive(0, 16'h0020, mix(v, 16'h0020));
    v2 = v;
    v2[5*DW +: DW] = 32'hB;
    drive(0, 16'h0020, mix(v2, 16'h0020));
    chk("t5_err_ov", err_overflow, 1'b1);
    drive(0, 16'hFFDF, mix(v, 16'hFFDF));
    m_ready = 1'b1;
    drive(0, '0, rand_vec());
    m_ready = 1'b0;
    chk("t5_col5", m_data[63:32], 32'hA);
    drain(20);

    // 6: reset in the middle of beat 2
    m_ready = 1'b0;
    drive(1, '0, '0);
    send_cols(rand_vec(), 1);
    m_ready = 1'b1;
    drive(0, '0, rand_vec());
    drive(0, '0, rand_vec());
    m_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_valid_rst", m_valid, 1'b0);
    chk("t6_cnt_rst", vec_count, 32'd0);
    chk("t6_err_rst", {err_overflow, err_credit}, 2'b00);
    chk("t6_cr_rst", collect_ready, 1'b1);
    @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    drive(1, '0, '0);
    send_cols(rand_vec(), 2);
    drain(20);
    chk("t6_cnt_after", vec_count, 32'd1);

    // Randomized traffic with random back-pressure
    rand_ready = 1;
    for (int n = 0; n < 30; n++) begin
      wait_credit(40);
      drive(1, '0, '0);
      send_cols(rand_vec(), $urandom_range(0, 2));
    end
    rand_ready = 0;
    drain(200);
    chk("rand_cnt", vec_count, m_cnt);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
